vid_pattern_gen: RTL and testbench
==================================

Name: vid_pattern_gen

Overview:
Synthetic video source in the pixel clock domain. It generates 8-bit pixel data plus vsync, hsync and vde timing, and feeds the linebuffer write stage directly. It replaces the sensor front end for bring-up and for DMA/framebuffer verification. Four test patterns are available, and the pattern selection and enable are frame-synchronous.

Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (pclk cycles)
- H_SYNC, 96, hsync width (pclk cycles)
- H_BP, 48, horizontal back porch (pclk cycles)
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- CHECK_SHIFT, 3, checkerboard square size is 2^CHECK_SHIFT pixels/lines

Ports:
- pclk  in  1  pixel clock
- reset_n  in  1  asynchronous active-low reset
- en  in  1  run request; sampled only at frame boundaries
- mode  in  2  pattern select; latched at frame start
- vsync  out  1  vertical sync, active high
- hsync  out  1  horizontal sync, active low
- vde  out  1  video data enable, high on active pixels
- o_data  out  8  pixel data
- frame_start  out  1  single-cycle pulse coincident with the first pixel of each frame
- frame_count  out  16  number of frames completed

Behaviour:
- Clocking and reset:
  - Single clock domain: pclk.
  - reset_n is asynchronous, active low.
  - Reset values: vsync=0, hsync=1, vde=0, o_data=0, frame_start=0, frame_count=0. State=IDLE, h=0, v=0, mode_q=0.
- Totals:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP
  - Internal h and v counters are 12 bits wide.
- States:
  - IDLE: h and v held at 0. Outputs held at idle values: vsync=0, hsync=1, vde=0, o_data=0, frame_start=0.
  - IDLE -> RUN on the edge that samples en=1. On that same edge, mode_q <= mode.
  - RUN: h increments each cycle. When h=H_TOTAL-1, h wraps to 0 and v increments.
  - At the last pixel (h=H_TOTAL-1, v=V_TOTAL-1):
    - frame_count increments, wrapping at 2^16.
    - If en=1: h=v=0, mode_q <= mode, stay in RUN.
    - If en=0: go to IDLE.
  - en deasserted mid-frame has no effect until the frame completes. mode changes mid-frame are ignored until the next frame.
- Timing decode (combinational from h, v, state; registered once into the outputs):
  - vde = RUN && h<H_ACTIVE && v<V_ACTIVE
  - hsync = 0 iff RUN && H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC
  - vsync = 1 iff RUN && V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, for all h in those lines. vsync edges coincide with h=0.
  - frame_start = RUN && h==0 && v==0
- Latency and alignment:
  - Outputs are registered, so every output reflects the counter state of the previous cycle.
  - All outputs are mutually aligned.
  - First vde appears one edge after the IDLE->RUN edge.
- Pixel data (only when vde; otherwise o_data=0):
  - mode 0: h[7:0], horizontal ramp
  - mode 1: v[7:0], vertical ramp
  - mode 2: (h[CHECK_SHIFT]^v[CHECK_SHIFT]) ? 8'hFF : 8'h00
  - mode 3: frame_count[7:0], flat field changing per frame
- Boundary conditions:
  - Back-to-back frames have no gap cycle: the first pixel of frame N+1 follows the last blanking cycle of frame N.
  - en toggling during IDLE is harmless. en must be high at a sampling edge for RUN to start.
  - Reset asserted mid-frame forces the reset values immediately and asynchronously. After release, the block waits in IDLE for en.
  - Any parameter that is 0 removes that interval. H_ACTIVE, V_ACTIVE, H_SYNC and V_SYNC must be >= 1.

Test Plan:
Test Plan parameters, used unless stated: H=8/2/2/2 (H_TOTAL=14), V=4/1/1/1 (V_TOTAL=7), CHECK_SHIFT=1.
1. Reset, then en=1, mode=0 → on the edge after start, vde=1, frame_start=1, o_data=0. Next 7 cycles give o_data=1..7. Then vde=0 for 6 cycles. hsync=0 exactly on cycles 10-11 of each line.
2. Run 2 frames, mode=1 → vde high for 8 cycles on lines 0-3 with o_data=line index. vsync=1 for all 14 cycles of line 5 only. frame_count reads 1 then 2. frame_start period is 98 cycles.
3. mode=2 → line 0 is 00,00,FF,FF,00,00,FF,FF. Line 2 is inverted.
4. mode=3, en held for 3 frames → active data is 00 in frame 0, 01 in frame 1, 02 in frame 2. Switching mode to 0 mid-frame-1 takes effect only at frame 2.
5. Drop en mid-frame → the frame completes fully (vsync line present), then IDLE outputs hold. Re-raising en restarts at (0,0) with frame_start=1.
6. Assert reset_n low mid-line, between clock edges → outputs go to reset values immediately, frame_count=0. The block stays idle until en is sampled high.

Source files
------------

// File: rtl/vid_pattern_gen_if.sv
// vid_pattern_gen_if: video timing and pixel bus from the pattern source to the linebuffer writer
interface vid_pattern_gen_if;
    logic        vsync;
    logic        hsync;
    logic        vde;
    logic [7:0]  o_data;
    logic        frame_start;
    logic [15:0] frame_count;

    modport master (
        output vsync, hsync, vde, o_data, frame_start, frame_count
    );

    modport slave (
        input vsync, hsync, vde, o_data, frame_start, frame_count
    );
endinterface

// File: rtl/vid_pattern_gen.sv
// vid_pattern_gen: synthetic video source with frame-synchronous pattern select and run control
module vid_pattern_gen #(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned H_FP        = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BP        = 48,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned V_FP        = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BP        = 33,
    parameter int unsigned CHECK_SHIFT = 3
) (
    input  logic               pclk,
    input  logic               reset_n,
    input  logic               en,
    input  logic [1:0]         mode,
    vid_pattern_gen_if.master  vid
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [11:0] H_TOTAL = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam logic [11:0] V_TOTAL = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam logic [11:0] H_ACT   = 12'(H_ACTIVE);
    localparam logic [11:0] V_ACT   = 12'(V_ACTIVE);
    localparam logic [11:0] HS_BEG  = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END  = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] VS_BEG  = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_END  = 12'(V_ACTIVE + V_FP + V_SYNC);

    state_t      state_q, state_d;
    logic [11:0] h_q, h_d;
    logic [11:0] v_q, v_d;
    logic [1:0]  mode_q, mode_d;
    logic [15:0] frame_count_q, frame_count_d;
    logic        vsync_q, vsync_d;
    logic        hsync_q, hsync_d;
    logic        vde_q, vde_d;
    logic [7:0]  data_q, data_d;
    logic        frame_start_q, frame_start_d;

    logic        run;
    logic        last_h;
    logic        last_v;
    logic [7:0]  pix;

    assign run    = (state_q == RUN);
    assign last_h = (h_q == H_TOTAL - 12'd1);
    assign last_v = (v_q == V_TOTAL - 12'd1);

    // Raster counters and run control; en and mode only take effect at a frame boundary
    always_comb begin
        state_d       = state_q;
        h_d           = h_q;
        v_d           = v_q;
        mode_d        = mode_q;
        frame_count_d = frame_count_q;
        if (!run) begin
            h_d = '0;
            v_d = '0;
            if (en) begin
                state_d = RUN;
                mode_d  = mode;
            end
        end else if (!last_h) begin
            h_d = h_q + 12'd1;
        end else if (!last_v) begin
            h_d = '0;
            v_d = v_q + 12'd1;
        end else begin
            h_d           = '0;
            v_d           = '0;
            frame_count_d = frame_count_q + 16'd1;
            if (en) begin
                mode_d = mode;
            end else begin
                state_d = IDLE;
            end
        end
    end

    // Timing and pixel decode from the current raster position; idle forces blanking values
    always_comb begin
        vde_d         = run && (h_q < H_ACT) && (v_q < V_ACT);
        hsync_d       = !(run && (h_q >= HS_BEG) && (h_q < HS_END));
        vsync_d       = run && (v_q >= VS_BEG) && (v_q < VS_END);
        frame_start_d = run && (h_q == 12'd0) && (v_q == 12'd0);
        pix = (mode_q == 2'd0) ? h_q[7:0] :
              (mode_q == 2'd1) ? v_q[7:0] :
              (mode_q == 2'd2) ? {8{h_q[CHECK_SHIFT] ^ v_q[CHECK_SHIFT]}} :
                                 frame_count_q[7:0];
        data_d = vde_d ? pix : 8'h00;
    end

    // State, counters and one register stage on every output so all outputs stay aligned
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            h_q           <= '0;
            v_q           <= '0;
            mode_q        <= '0;
            frame_count_q <= '0;
            vsync_q       <= 1'b0;
            hsync_q       <= 1'b1;
            vde_q         <= 1'b0;
            data_q        <= 8'h00;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            h_q           <= h_d;
            v_q           <= v_d;
            mode_q        <= mode_d;
            frame_count_q <= frame_count_d;
            vsync_q       <= vsync_d;
            hsync_q       <= hsync_d;
            vde_q         <= vde_d;
            data_q        <= data_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vid.vsync       = vsync_q;
    assign vid.hsync       = hsync_q;
    assign vid.vde         = vde_q;
    assign vid.o_data      = data_q;
    assign vid.frame_start = frame_start_q;
    assign vid.frame_count = frame_count_q;

endmodule

// File: tb/tb_vid_pattern_gen.sv
// tb_vid_pattern_gen: scoreboard bench comparing the generator against a frame-position reference model
module tb_vid_pattern_gen;

    localparam int HA = 8, HF = 2, HS = 2, HB = 2;
    localparam int VA = 4, VF = 1, VS = 1, VB = 1;
    localparam int CS = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FR = HT * VT;

    typedef struct {
        logic        vs;
        logic        hs;
        logic        de;
        logic [7:0]  d;
        logic        fs;
        logic [15:0] fc;
    } exp_t;

    logic       pclk = 1'b0;
    logic       reset_n = 1'b0;
    logic       en = 1'b0;
    logic [1:0] mode = 2'd0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    exp_t q[$];

    bit m_run = 0;
    int m_pos = 0;
    int m_fc = 0;
    int m_mode = 0;

    vid_pattern_gen_if vif();

    vid_pattern_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .CHECK_SHIFT(CS)
    ) dut (
        .pclk(pclk),
        .reset_n(reset_n),
        .en(en),
        .mode(mode),
        .vid(vif)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_vsync"}, int'(vif.vsync), 0);
        chk({tag, "_hsync"}, int'(vif.hsync), 1);
        chk({tag, "_vde"}, int'(vif.vde), 0);
        chk({tag, "_data"}, int'(vif.o_data), 0);
        chk({tag, "_fstart"}, int'(vif.frame_start), 0);
        chk({tag, "_fcount"}, int'(vif.frame_count), 0);
    endtask

    // Drive one cycle of inputs at the falling edge and predict the outputs after the next rising edge
    task automatic cycle(input logic rst_v, input logic e, input logic [1:0] m);
        exp_t x;
        int h, v;
        @(negedge pclk);
        reset_n = rst_v;
        en = e;
        mode = m;
        if (!reset_n) begin
            m_run = 0;
            m_pos = 0;
            m_fc = 0;
            m_mode = 0;
        end
        h = m_pos % HT;
        v = m_pos / HT;
        x.de = m_run && h < HA && v < VA;
        x.hs = !(m_run && h >= HA + HF && h < HA + HF + HS);
        x.vs = m_run && v >= VA + VF && v < VA + VF + VS;
        x.fs = m_run && m_pos == 0;
        if (!x.de) x.d = 8'h00;
        else if (m_mode == 0) x.d = 8'(h);
        else if (m_mode == 1) x.d = 8'(v);
        else if (m_mode == 2) x.d = (((h >> CS) ^ (v >> CS)) & 1) != 0 ? 8'hFF : 8'h00;
        else x.d = 8'(m_fc);
        if (reset_n) begin
            if (!m_run) begin
                if (e) begin
                    m_run = 1;
                    m_pos = 0;
                    m_mode = int'(m);
                end
            end else if (m_pos == FR - 1) begin
                m_fc = (m_fc + 1) % 65536;
                if (e) begin
                    m_pos = 0;
                    m_mode = int'(m);
                end else begin
                    m_run = 0;
                end
            end else begin
                m_pos++;
            end
        end
        x.fc = 16'(m_fc);
        q.push_back(x);
    endtask

    // Monitor: one prediction per rising edge, sampled just after the edge
    initial begin
        exp_t x;
        forever begin
            @(posedge pclk);
            #1;
            cyc++;
            if (q.size() > 0) begin
                x = q.pop_front();
                chk("vsync", int'(vif.vsync), int'(x.vs));
                chk("hsync", int'(vif.hsync), int'(x.hs));
                chk("vde", int'(vif.vde), int'(x.de));
                chk("o_data", int'(vif.o_data), int'(x.d));
                chk("frame_start", int'(vif.frame_start), int'(x.fs));
                chk("frame_count", int'(vif.frame_count), int'(x.fc));
            end
        end
    end

    initial begin
        @(posedge pclk);
        #2;
        chk_reset_vals("por");
        repeat (3) cycle(1'b0, 1'b0, 2'd0);
        repeat (6) cycle(1'b1, 1'b0, 2'($urandom));
        cycle(1'b1, 1'b1, 2'd0);
        repeat (FR - 1) cycle(1'b1, 1'b1, 2'd1);
        repeat (2 * FR) cycle(1'b1, 1'b1, 2'd2);
        repeat (FR - 10) cycle(1'b1, 1'b1, 2'd3);
        repeat (FR + 10) cycle(1'b1, 1'b1, 2'd3);
        repeat (40) cycle(1'b1, 1'b1, 2'd0);
        repeat (2 * FR - 30) cycle(1'b1, 1'b1, 2'd2);
        repeat (FR + 20) cycle(1'b1, 1'b0, 2'd1);
        repeat (20) cycle(1'b1, 1'b1, 2'd1);
        @(posedge pclk);
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        repeat (3) cycle(1'b0, 1'b1, 2'd1);
        repeat (5) cycle(1'b1, 1'b0, 2'd3);
        repeat (1500) cycle(1'b1, ($urandom % 10) != 0, 2'($urandom));
        repeat (2) @(posedge pclk);
        #2;
        chk("queue_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
